// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier: clears the array, streams y LSB-first,
// gathers the 2*WIDTH-bit serial product and hands it out on a valid/ready port.
module spm_seq_ctrl #(
    parameter  int WIDTH = 32,
    parameter  int P_LAT = 1,
    localparam int CNT_W = $clog2(2*WIDTH+P_LAT+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy,
    output logic               spm_clr,
    output logic [WIDTH-1:0]   spm_x,
    output logic               spm_y,
    input  logic               spm_p
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(2*WIDTH+P_LAT-1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(WIDTH-1);
    localparam logic [CNT_W-1:0] SMP_FROM = CNT_W'(P_LAT);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     y_sh_q, y_sh_d;
    logic [2*WIDTH-1:0]   p_sh_q, p_sh_d;
    logic [WIDTH-1:0]     spm_x_q, spm_x_d;
    logic                 spm_y_q, spm_y_d;
    logic                 spm_clr_q, spm_clr_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   out_p_q, out_p_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            y_sh_q      <= '0;
            p_sh_q      <= '0;
            spm_x_q     <= '0;
            spm_y_q     <= 1'b0;
            spm_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            y_sh_q      <= y_sh_d;
            p_sh_q      <= p_sh_d;
            spm_x_q     <= spm_x_d;
            spm_y_q     <= spm_y_d;
            spm_clr_q   <= spm_clr_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)            state_d = S_CLEAR;
            S_CLEAR:                          state_d = S_RUN;
            S_RUN:   if (cnt_q == RUN_LAST)   state_d = S_DONE;
            S_DONE:  if (out_ready)           state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so each branch computes what the next cycle presents.
    always_comb begin
        cnt_d       = cnt_q;
        y_sh_d      = y_sh_q;
        p_sh_d      = p_sh_q;
        spm_x_d     = spm_x_q;
        spm_y_d     = 1'b0;
        spm_clr_d   = 1'b0;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    spm_x_d   = in_x;
                    y_sh_d    = in_y;
                    spm_clr_d = 1'b1;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                spm_y_d = y_sh_q[0];
                y_sh_d  = y_sh_q >> 1;
            end
            S_RUN: begin
                cnt_d   = cnt_q + 1'b1;
                // Upper WIDTH y bits go out as zero to flush the carry-save array.
                spm_y_d = (cnt_q < Y_LAST) ? y_sh_q[0] : 1'b0;
                y_sh_d  = y_sh_q >> 1;
                if (cnt_q >= SMP_FROM)
                    p_sh_d = {spm_p, p_sh_q[2*WIDTH-1:1]};
                if (cnt_q == RUN_LAST) begin
                    out_p_d     = p_sh_d;
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready)
                    out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;
    assign spm_clr   = spm_clr_q;
    assign spm_x     = spm_x_q;
    assign spm_y     = spm_y_q;

endmodule
